// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator with double-buffered MMIO geometry.
// Produces registered hsync/vsync/data_en and signed pixel coordinates (0,0 = first active pixel).
// Optional feature: define VIDEO_TIMING_GEN_IRQ_EN to build the vblank interrupt pending flag.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               sel,
    output logic               ready,
    input  logic [3:0]         wstrb,
    input  logic [23:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               hsync,
    output logic               vsync,
    output logic               data_en,
    output logic signed [15:0] xpos,
    output logic signed [15:0] ypos,
    output logic               frame_start,
    output logic               irq
);

    typedef struct packed {
        logic [11:0] ha;
        logic [7:0]  hfp;
        logic [7:0]  hsw;
        logic [7:0]  hbp;
        logic [11:0] va;
        logic [7:0]  vfp;
        logic [7:0]  vsw;
        logic [7:0]  vbp;
    } geom_t;

    localparam geom_t GEOM_RST = '{ha: 12'(H_ACTIVE), hfp: 8'(H_FP), hsw: 8'(H_SYNC), hbp: 8'(H_BP),
                                   va: 12'(V_ACTIVE), vfp: 8'(V_FP), vsw: 8'(V_SYNC), vbp: 8'(V_BP)};
    localparam logic [15:0] X_RST = 16'(-(H_FP + H_SYNC + H_BP));
    localparam logic [15:0] Y_RST = 16'(-(V_FP + V_SYNC + V_BP));

    // Negated sum of blanking segments, i.e. the coordinate where a segment run begins.
    function automatic logic signed [15:0] neg_sum(input logic [7:0] a, input logic [7:0] b,
                                                   input logic [7:0] c);
        return $signed(16'd0 - (16'(a) + 16'(b) + 16'(c)));
    endfunction

    // Zero sizes would stall the raster, so they are stored as 1.
    function automatic logic [11:0] nz12(input logic [11:0] v);
        return (v == 12'd0) ? 12'd1 : v;
    endfunction

    function automatic logic [7:0] nz8(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    geom_t              live, pend, geo_n, pend_n;
    logic               enable, hs_pol, vs_pol;
    logic [2:0]         ctrl_n;
    logic [15:0]        frame_cnt;
    logic               access, wr;
    logic [2:0]         idx;
    logic               line_end, frame_end, copy;
    logic signed [15:0] x_n, y_n;
    logic               hs_n, vs_n, de_n, fs_n;
    logic [31:0]        rmux;
    logic               irq_pend;
    logic               unused_bits;

    assign access      = sel && !ready;
    assign wr          = access && (wstrb != 4'd0);
    assign idx         = addr[4:2];
    assign unused_bits = ^{addr[23:5], addr[1:0], wdata[31:24]};

    // Next raster position and the sync/enable levels that go with it, using the geometry of the next pixel.
    always_comb begin
        line_end  = (xpos == $signed(16'(live.ha) - 16'd1));
        frame_end = line_end && (ypos == $signed(16'(live.va) - 16'd1));
        copy      = enable && frame_end;
        geo_n     = copy ? pend : live;
        if (!enable) begin
            x_n = neg_sum(live.hfp, live.hsw, live.hbp);
            y_n = neg_sum(live.vfp, live.vsw, live.vbp);
        end else if (line_end) begin
            x_n = neg_sum(geo_n.hfp, geo_n.hsw, geo_n.hbp);
            y_n = frame_end ? neg_sum(geo_n.vfp, geo_n.vsw, geo_n.vbp) : ypos + 16'sd1;
        end else begin
            x_n = xpos + 16'sd1;
            y_n = ypos;
        end
        hs_n = enable && (x_n >= neg_sum(8'd0, geo_n.hsw, geo_n.hbp)) && (x_n < neg_sum(8'd0, 8'd0, geo_n.hbp));
        vs_n = enable && (y_n >= neg_sum(8'd0, geo_n.vsw, geo_n.vbp)) && (y_n < neg_sum(8'd0, 8'd0, geo_n.vbp));
        de_n = enable && (x_n >= 16'sd0) && (x_n < $signed(16'(geo_n.ha)))
                      && (y_n >= 16'sd0) && (y_n < $signed(16'(geo_n.va)));
        fs_n = enable && (x_n == 16'sd0) && (y_n == 16'sd0);
    end

    // Byte-strobed register writes into the pending geometry and CTRL.
    always_comb begin
        pend_n = pend;
        ctrl_n = {vs_pol, hs_pol, enable};
        if (wr) begin
            case (idx)
                3'd0: pend_n.ha = nz12({wstrb[1] ? wdata[11:8] : pend.ha[11:8],
                                        wstrb[0] ? wdata[7:0]  : pend.ha[7:0]});
                3'd1: begin
                    pend_n.hfp = wstrb[0] ? wdata[7:0] : pend.hfp;
                    pend_n.hsw = nz8(wstrb[1] ? wdata[15:8] : pend.hsw);
                    pend_n.hbp = wstrb[2] ? wdata[23:16] : pend.hbp;
                end
                3'd2: pend_n.va = nz12({wstrb[1] ? wdata[11:8] : pend.va[11:8],
                                        wstrb[0] ? wdata[7:0]  : pend.va[7:0]});
                3'd3: begin
                    pend_n.vfp = wstrb[0] ? wdata[7:0] : pend.vfp;
                    pend_n.vsw = nz8(wstrb[1] ? wdata[15:8] : pend.vsw);
                    pend_n.vbp = wstrb[2] ? wdata[23:16] : pend.vbp;
                end
                3'd4: if (wstrb[0]) ctrl_n = wdata[2:0];
                default: ;
            endcase
        end
    end

`ifdef VIDEO_TIMING_GEN_IRQ_EN
    // Vblank pending flag: set when the raster wraps into vblank, cleared by STATUS bit 1; set wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) irq_pend <= 1'b0;
        else if (copy) irq_pend <= 1'b1;
        else if (wr && (idx == 3'd5) && wstrb[0] && wdata[1]) irq_pend <= 1'b0;
    end
    assign irq = irq_pend;
`else
    assign irq_pend = 1'b0;
    assign irq      = 1'b0;
`endif

    // Read mux; geometry reads return the pending copy.
    always_comb begin
        case (idx)
            3'd0:    rmux = {20'd0, pend.ha};
            3'd1:    rmux = {8'd0, pend.hbp, pend.hsw, pend.hfp};
            3'd2:    rmux = {20'd0, pend.va};
            3'd3:    rmux = {8'd0, pend.vbp, pend.vsw, pend.vfp};
            3'd4:    rmux = {29'd0, vs_pol, hs_pol, enable};
            3'd5:    rmux = {frame_cnt, 14'd0, irq_pend, ypos[15]};
            default: rmux = 32'd0;
        endcase
    end

    // Raster outputs all update on the same edge; sync polarity comes from the incoming CTRL value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xpos        <= X_RST;
            ypos        <= Y_RST;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            data_en     <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            xpos        <= x_n;
            ypos        <= y_n;
            hsync       <= ~(hs_n ^ ctrl_n[1]);
            vsync       <= ~(vs_n ^ ctrl_n[2]);
            data_en     <= de_n;
            frame_start <= fs_n;
            if (fs_n) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Config registers; live geometry takes the pre-write pending value at the frame wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            live                      <= GEOM_RST;
            pend                      <= GEOM_RST;
            {vs_pol, hs_pol, enable}  <= 3'b111;
        end else begin
            pend                      <= pend_n;
            {vs_pol, hs_pol, enable}  <= ctrl_n;
            if (copy) live <= pend;
        end
    end

    // Single-cycle MMIO acknowledge; sel is ignored while ready is high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready <= 1'b0;
            rdata <= 32'd0;
        end else begin
            ready <= access;
            rdata <= access ? rmux : 32'd0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed self-checking bench for video_timing_gen.
// A default-parameter instance checks full VGA reset/timing; a tiny-geometry instance covers the rest.
module tb_video_timing_gen;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance: HA=8 HFP=2 HSYNC=3 HBP=1 (line 14), VA=4 VFP=1 VSYNC=2 VBP=1 (8 lines, frame 112)
    logic               resetn, sel, ready, hsync, vsync, data_en, frame_start, irq;
    logic [3:0]         wstrb;
    logic [23:0]        addr;
    logic [31:0]        wdata, rdata;
    logic signed [15:0] xpos, ypos;

    logic               resetn_d, ready_d, hsync_d, vsync_d, data_en_d, frame_start_d, irq_d;
    logic [31:0]        rdata_d;
    logic signed [15:0] xpos_d, ypos_d;

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut (
        .clk(clk), .resetn(resetn), .sel(sel), .ready(ready), .wstrb(wstrb), .addr(addr),
        .wdata(wdata), .rdata(rdata), .hsync(hsync), .vsync(vsync), .data_en(data_en),
        .xpos(xpos), .ypos(ypos), .frame_start(frame_start), .irq(irq)
    );

    video_timing_gen dut_def (
        .clk(clk), .resetn(resetn_d), .sel(1'b0), .ready(ready_d), .wstrb(4'd0), .addr(24'd0),
        .wdata(32'd0), .rdata(rdata_d), .hsync(hsync_d), .vsync(vsync_d), .data_en(data_en_d),
        .xpos(xpos_d), .ypos(ypos_d), .frame_start(frame_start_d), .irq(irq_d)
    );

    int checks = 0;
    int errors = 0;
    int k = 0;

    typedef struct {
        int k; int x; int y; int hs; int vs; int de; int fs;
    } vec_t;

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic resetSmall;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        k = 0;
    endtask

    task automatic applyStimulus(input logic [2:0] idx, input logic [3:0] strb,
                                 input logic [31:0] data, output logic [31:0] rd);
        bit got;
        got   = 1'b0;
        rd    = 32'd0;
        sel   = 1'b1;
        addr  = {19'd0, idx, 2'b00};
        wstrb = strb;
        wdata = data;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (ready) begin
                got = 1'b1;
                rd  = rdata;
            end
        end
        sel   = 1'b0;
        wstrb = 4'd0;
        if (!got) checkOutput("mmio_ack", 0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        vecs [13];
        int          cyc, hs_cnt, vs_cnt, hs_first, hs_last, de_cyc, n, nfs;
        int          fsk [3];
        bit          hs_seen, irqmax;
        logic [3:0]  rpat;
        logic [31:0] rd, stat;

        vecs = '{'{0, -6, -4, 0, 0, 0, 0}, '{2, -4, -4, 1, 0, 0, 0}, '{4, -2, -4, 1, 0, 0, 0},
                 '{5, -1, -4, 0, 0, 0, 0}, '{14, -6, -3, 0, 1, 0, 0}, '{36, 2, -2, 0, 1, 0, 0},
                 '{42, -6, -1, 0, 0, 0, 0}, '{62, 0, 0, 0, 0, 1, 1}, '{69, 7, 0, 0, 0, 1, 0},
                 '{70, -6, 1, 0, 0, 0, 0}, '{111, 7, 3, 0, 0, 1, 0}, '{112, -6, -4, 0, 0, 0, 0},
                 '{124, 6, -4, 0, 0, 0, 0}};

        resetn = 1'b0; resetn_d = 1'b0; sel = 1'b0; wstrb = 4'd0; addr = 24'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);

        // Reset values, default geometry
        checkOutput("def_rst_x", xpos_d, -160);
        checkOutput("def_rst_y", ypos_d, -45);
        checkOutput("def_rst_hs", hsync_d, 0);
        checkOutput("def_rst_vs", vsync_d, 0);
        checkOutput("def_rst_de", data_en_d, 0);
        checkOutput("def_rst_fs", frame_start_d, 0);
        checkOutput("def_rst_irq", irq_d, 0);
        checkOutput("def_rst_ready", ready_d, 0);
        checkOutput("def_rst_rdata", rdata_d, 0);
        checkOutput("small_rst_x", xpos, -6);
        checkOutput("small_rst_y", ypos, -4);

        // Default raster: first active pixel, hsync window, vsync length
        resetn_d = 1'b1; resetn = 1'b1;
        cyc = 0; hs_cnt = 0; vs_cnt = 0; hs_first = 0; hs_last = 0; de_cyc = -1; hs_seen = 1'b0;
        while (de_cyc < 0 && cyc < 40000) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (cyc <= 800 && hsync_d) begin
                if (!hs_seen) begin hs_first = xpos_d; hs_seen = 1'b1; end
                hs_last = xpos_d;
                hs_cnt++;
            end
            if (vsync_d) vs_cnt++;
            if (data_en_d) de_cyc = cyc;
        end
        checkOutput("def_first_de_cycle", de_cyc, 36160);
        checkOutput("def_fs_with_de", frame_start_d, 1);
        checkOutput("def_de_x", xpos_d, 0);
        checkOutput("def_de_y", ypos_d, 0);
        checkOutput("def_hs_width", hs_cnt, 96);
        checkOutput("def_hs_first_x", hs_first, -144);
        checkOutput("def_hs_last_x", hs_last, -49);
        checkOutput("def_vs_cycles", vs_cnt, 1600);

        // Small raster directed vectors
        resetSmall();
        foreach (vecs[i]) begin
            while (k < vecs[i].k) tick();
            checkOutput($sformatf("vec%0d_x", i), xpos, vecs[i].x);
            checkOutput($sformatf("vec%0d_y", i), ypos, vecs[i].y);
            checkOutput($sformatf("vec%0d_hs", i), hsync, vecs[i].hs);
            checkOutput($sformatf("vec%0d_vs", i), vsync, vecs[i].vs);
            checkOutput($sformatf("vec%0d_de", i), data_en, vecs[i].de);
            checkOutput($sformatf("vec%0d_fs", i), frame_start, vecs[i].fs);
        end

        // Frame counter after three frames, ready pulses with sel held four cycles
        resetSmall();
        irqmax = 1'b0;
        while (k < 300) begin
            tick();
            if (irq) irqmax = 1'b1;
        end
`ifndef VIDEO_TIMING_GEN_IRQ_EN
        checkOutput("irq_off_3frames", irqmax, 0);
`endif
        sel = 1'b1; addr = {19'd0, 3'd5, 2'b00}; wstrb = 4'd0; rpat = 4'd0; stat = 32'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            rpat = {rpat[2:0], ready};
            if (ready) stat = rdata;
        end
        sel = 1'b0;
        checkOutput("ready_pattern", rpat, 4'b1010);
        checkOutput("frame_cnt_3", stat[31:16], 3);
`ifndef VIDEO_TIMING_GEN_IRQ_EN
        checkOutput("status_irq_off", stat[1], 0);
`endif

        // Mid-frame HA change: readback immediate, geometry swaps at frame wrap
        resetSmall();
        applyStimulus(3'd0, 4'hF, 32'd4, rd);
        applyStimulus(3'd0, 4'h0, 32'd0, rd);
        checkOutput("hcfg_readback", rd, 4);
        nfs = 0; fsk[0] = -1; fsk[1] = -1; fsk[2] = -1;
        while (nfs < 3 && k < 600) begin
            tick();
            if (frame_start) begin fsk[nfs] = k; nfs++; end
        end
        checkOutput("fs_old_geom", fsk[0], 62);
        checkOutput("fs_new_geom_1", fsk[1], 158);
        checkOutput("fs_new_geom_2", fsk[2], 238);

        // Register file: zero clamps, byte strobes, unused indices
        applyStimulus(3'd0, 4'hF, 32'd0, rd);
        applyStimulus(3'd0, 4'h0, 32'd0, rd);
        checkOutput("hcfg_zero_is_1", rd, 1);
        applyStimulus(3'd1, 4'hF, 32'h0000_0002, rd);
        applyStimulus(3'd1, 4'h0, 32'd0, rd);
        checkOutput("hblk_sync_zero", rd, 32'h0000_0102);
        applyStimulus(3'd1, 4'h1, 32'hFFFF_FF05, rd);
        applyStimulus(3'd1, 4'h0, 32'd0, rd);
        checkOutput("hblk_byte0_only", rd, 32'h0000_0105);
        applyStimulus(3'd3, 4'h0, 32'd0, rd);
        checkOutput("vblk_default", rd, 32'h0001_0201);
        applyStimulus(3'd6, 4'hF, 32'hFFFF_FFFF, rd);
        applyStimulus(3'd6, 4'h0, 32'd0, rd);
        checkOutput("idx6_reads_0", rd, 0);
        applyStimulus(3'd4, 4'h0, 32'd0, rd);
        checkOutput("ctrl_default", rd, 7);

        // Reset mid-frame returns pending registers to parameter values
        tick(); tick(); tick();
        resetn = 1'b0;
        #1;
        checkOutput("midrst_x", xpos, -6);
        checkOutput("midrst_y", ypos, -4);
        checkOutput("midrst_de", data_en, 0);
        @(negedge clk);
        resetn = 1'b1; k = 0;
        applyStimulus(3'd0, 4'h0, 32'd0, rd);
        checkOutput("midrst_hcfg", rd, 8);
        applyStimulus(3'd1, 4'h0, 32'd0, rd);
        checkOutput("midrst_hblk", rd, 32'h0001_0302);

        // Disable mid-line, hold, polarity flip, re-enable
        resetSmall();
        while (k < 20) tick();
        applyStimulus(3'd4, 4'h1, 32'h6, rd);
        repeat (10) tick();
        checkOutput("dis_x", xpos, -6);
        checkOutput("dis_y", ypos, -4);
        checkOutput("dis_de", data_en, 0);
        checkOutput("dis_hs", hsync, 0);
        checkOutput("dis_vs", vsync, 0);
        checkOutput("dis_fs", frame_start, 0);
        applyStimulus(3'd4, 4'h1, 32'h4, rd);
        checkOutput("pol_hs_flip", hsync, 1);
        checkOutput("pol_vs_keep", vsync, 0);
        applyStimulus(3'd4, 4'h1, 32'h7, rd);
        checkOutput("reen_x", xpos, -6);
        checkOutput("reen_hs", hsync, 0);
        n = 0;
        while (!frame_start && n < 200) begin tick(); n++; end
        checkOutput("reen_fs_delay", n, 62);

`ifdef VIDEO_TIMING_GEN_IRQ_EN
        // Vblank interrupt set at frame wrap, cleared by STATUS write
        resetSmall();
        while (k < 111) tick();
        checkOutput("irq_before_wrap", irq, 0);
        tick();
        checkOutput("irq_at_wrap", irq, 1);
        checkOutput("irq_wrap_y", ypos, -4);
        applyStimulus(3'd5, 4'h0, 32'd0, rd);
        checkOutput("status_irq", rd, 32'h0001_0003);
        applyStimulus(3'd5, 4'h1, 32'h2, rd);
        checkOutput("irq_cleared", irq, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Programmable raster timing generator feeding the text/graphics pixel pipeline of the picosoc VGA path. It produces registered hsync, vsync, data_en and signed pixel coordinates xpos/ypos, with xpos/ypos = 0 at the first active pixel and negative values throughout blanking, so downstream stages can pre-fetch before the active region. Mode geometry is run-time programmable over the picosoc MMIO bus. Writes are double-buffered and take effect only at a frame boundary.

## Interface
Parameters (reset values of the live and pending geometry registers):
- H_ACTIVE, 640, active pixels per line (12 bit)
- H_FP, 16, horizontal front porch (8 bit)
- H_SYNC, 96, hsync width (8 bit)
- H_BP, 48, horizontal back porch (8 bit)
- V_ACTIVE, 480, active lines (12 bit)
- V_FP, 10; V_SYNC, 2; V_BP, 33, vertical equivalents (8 bit each)

Ports:
- clk  in  1  pixel clock; the only clock
- resetn  in  1  asynchronous, active-low reset
- sel  in  1  MMIO select, held by the master until ready
- ready  out  1  one-cycle access acknowledge
- wstrb  in  4  byte write strobes; 0 = read
- addr  in  24  byte address; addr[4:2] selects the register
- wdata  in  32  write data
- rdata  out  32  read data, valid while ready = 1
- hsync, vsync  out  1  sync outputs, polarity per CTRL
- data_en  out  1  high while 0 ≤ xpos < HA and 0 ≤ ypos < VA
- xpos, ypos  out  16 signed  current pixel coordinates
- frame_start  out  1  one-cycle pulse when xpos = 0 and ypos = 0
- irq  out  1  vblank interrupt level (see Configuration)

## Operation
- Line order is back-to-front relative to active video: FP, SYNC, BP, then ACTIVE. HB = FP + SYNC + BP.
- xpos runs from -HB to HA-1. On reaching HA-1 it wraps to -HB and ypos increments.
- ypos runs from -VB to VA-1. On reaching VA-1 at xpos = HA-1, ypos wraps to -VB.
- hsync is active while -(SYNC+BP) ≤ xpos < -BP. vsync is active over the whole line range -(VSYNC+VBP) ≤ ypos < -VBP.
- Registers (word index):
  - 0 HCFG: [11:0] HA.
  - 1 HBLK: [7:0] FP, [15:8] SYNC, [23:16] BP.
  - 2 VCFG: [11:0] VA.
  - 3 VBLK: same layout as HBLK.
  - 4 CTRL: [0] enable (reset 1), [1] hs_pol (1 = active-high, reset 1), [2] vs_pol (reset 1).
  - 5 STATUS (read-only): [0] vblank (ypos < 0), [1] irq pending, [31:16] frame count.
  - Indices 6-7: reads return 0, writes are ignored.
- Byte strobes apply per byte. Reads of geometry registers return the pending values.
- Geometry writes land in pending registers. Pending is copied to live in the cycle where xpos = HA-1 and ypos = VA-1, so the next frame uses the new geometry from its first blanking pixel.
- Write of HA/VA = 0 or SYNC = 0 stores 1. FP/BP of 0 is legal.
- CTRL writes take effect on the next cycle. Polarity changes are immediate.
- enable = 0: counters are forced to (-HB, -VB) of the live geometry and held; data_en and frame_start are 0; syncs are inactive. On re-enable, counting starts from that position.
- Frame counter: 16 bit, increments on frame_start, wraps 0xFFFF → 0.

## Timing
- All outputs are registered and update together on the rising edge of clk. There is zero relative skew between syncs, data_en and coordinates.
- Reset values:
  - xpos = -(H_FP+H_SYNC+H_BP), ypos = -(V_FP+V_SYNC+V_BP).
  - hsync and vsync at their inactive level.
  - data_en, frame_start, irq, ready = 0; rdata = 0; frame count = 0.
- MMIO: ready pulses high exactly 1 cycle after sel is first seen. rdata is valid in that cycle. sel is ignored in the cycle ready is high, so one access never executes twice.
- Reset mid-frame: all state, including pending registers, returns to parameter values immediately.
- A write in the same cycle as the pending→live copy: the live registers take the old pending value; the new value applies at the following frame.

## Configuration
- VIDEO_TIMING_GEN_IRQ_EN defined:
  - irq pending sets in the cycle ypos becomes -VB (start of vblank).
  - Writing STATUS with wdata[1] = 1 clears it; a set and a clear in the same cycle leaves it set.
  - irq = pending.
- Not defined: irq is tied to 0, STATUS[1] reads 0, and the pending-flag logic is absent.

## Test plan
- Reset release with default parameters → xpos = -160, ypos = -45. First data_en rises at cycle 45×800 + 160 = 36160. frame_start coincides with it. Frame period is 420000 cycles.
- Default line → hsync active for exactly 96 cycles, from xpos = -144 to -49. vsync active for 1600 cycles, covering ypos = -35 and -34.
- Write HCFG = 320 mid-frame → lines remain 800 cycles until the end of the frame, then become 480 cycles. Readback of HCFG returns 320 immediately.
- CTRL enable = 0 mid-line, hold 100 cycles → outputs stay at (-160, -45) with data_en = 0. Re-enable → the next frame_start occurs 36160 cycles later.
- With VIDEO_TIMING_GEN_IRQ_EN: irq rises when ypos reaches -45. A STATUS write of 0x2 clears it. Without the macro, irq stays 0 across 3 frames.
- Read STATUS after 3 frame_start pulses → bits [31:16] = 3. ready is high for exactly 1 cycle per access while sel is held for 4 cycles.
